// File: rtl/core_pkg.sv
// Shared core types: register address, writeback source and issue FSM encodings.
package core_pkg;

    localparam int unsigned CORE_NREG = 32;
    localparam int unsigned CORE_XLEN = 32;
    localparam int unsigned CORE_AW   = $clog2(CORE_NREG);

    typedef logic [CORE_AW-1:0] regaddr_t;

    typedef enum logic {
        WB_LD = 1'b0,
        WB_MD = 1'b1
    } wb_src_e;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fsm_e;

    function automatic logic [CORE_NREG-1:0] reg_onehot(input regaddr_t idx);
        logic [CORE_NREG-1:0] mask;
        mask      = {CORE_NREG{1'b0}};
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_scoreboard.sv
// Per-register pending-write scoreboard with a write-through (bypassed) read view.
module issue_hazard_ctrl_scoreboard #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [AW-1:0]    set_idx_i,
    input  logic             clr_en_i,
    input  logic [AW-1:0]    clr_idx_i,
    output logic [WIDTH-1:0] pending_o,
    output logic [WIDTH-1:0] read_bypassed_o
);

    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] set_mask_s;
    logic [WIDTH-1:0] clr_mask_s;

    // Decode set/clear into masks; set is applied after clear so it wins on a collision.
    always_comb begin
        set_mask_s = {WIDTH{1'b0}};
        clr_mask_s = {WIDTH{1'b0}};
        if (set_en_i) begin
            set_mask_s[set_idx_i] = 1'b1;
        end else begin
            set_mask_s = {WIDTH{1'b0}};
        end
        if (clr_en_i) begin
            clr_mask_s[clr_idx_i] = 1'b1;
        end else begin
            clr_mask_s = {WIDTH{1'b0}};
        end
        read_bypassed_o = pending_q & ~clr_mask_s;
        pending_d       = read_bypassed_o | set_mask_s;
        pending_d[0]    = 1'b0;
    end

    // Pending bit storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= {WIDTH{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/issue_hazard_ctrl_sva.sv
// Protocol checks for the hazard controller: writebacks must target a pending register.
module issue_hazard_ctrl_sva #(
    parameter int unsigned NREG = 32,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input logic            clk,
    input logic            reset,
    input logic            rf_we_i,
    input logic [AW-1:0]   rf_waddr_i,
    input logic [NREG-1:0] pending_i
);

    wb_to_pending_a: assert property (@(posedge clk) disable iff (reset)
        rf_we_i |-> pending_i[rf_waddr_i]);

endmodule

// File: rtl/issue_hazard_ctrl.sv
// In-order issue hazard controller: RAW/WAW stall, long-latency writeback
// arbitration onto the single RF write port, and fence drain sequencing.
module issue_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned XLEN = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rs1,
    input  logic [$clog2(NREG)-1:0] iss_rs2,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    input  logic                    iss_rs1_used,
    input  logic                    iss_rs2_used,
    input  logic                    iss_rd_used,
    input  logic                    iss_long,
    output logic                    iss_ready,
    input  logic                    fence_req,
    output logic                    fence_ack,
    input  logic                    ld_wb_valid,
    input  logic [$clog2(NREG)-1:0] ld_wb_rd,
    input  logic [XLEN-1:0]         ld_wb_data,
    output logic                    ld_wb_ready,
    input  logic                    md_wb_valid,
    input  logic [$clog2(NREG)-1:0] md_wb_rd,
    input  logic [XLEN-1:0]         md_wb_data,
    output logic                    md_wb_ready,
    output logic                    rf_we,
    output logic [$clog2(NREG)-1:0] rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    idle
);

    localparam int unsigned AW = $clog2(NREG);
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};

    logic [NREG-1:0] pending_s;
    logic [NREG-1:0] eff_s;
    logic            hazard_s;
    logic            issue_fire_s;
    logic            set_en_s;
    logic            dec_s;
    logic            ld_gnt_s;
    logic            md_gnt_s;

    logic [AW-1:0]   cnt_q,       cnt_d;
    wb_src_e         rr_last_q,   rr_last_d;
    fsm_e            state_q,     state_d;
    logic            fence_ack_q, fence_ack_d;
    logic            rf_we_q,     rf_we_d;
    logic [AW-1:0]   rf_waddr_q,  rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q,  rf_wdata_d;

    issue_hazard_ctrl_scoreboard #(
        .WIDTH (NREG)
    ) u_scoreboard (
        .clk             (clk),
        .reset           (reset),
        .set_en_i        (set_en_s),
        .set_idx_i       (iss_rd),
        .clr_en_i        (rf_we_q),
        .clr_idx_i       (rf_waddr_q),
        .pending_o       (pending_s),
        .read_bypassed_o (eff_s)
    );

    issue_hazard_ctrl_sva #(
        .NREG (NREG)
    ) u_sva (
        .clk        (clk),
        .reset      (reset),
        .rf_we_i    (rf_we_q),
        .rf_waddr_i (rf_waddr_q),
        .pending_i  (pending_s)
    );

    // Zero-cycle stall decision against the bypassed pending view.
    always_comb begin
        hazard_s     = (iss_rs1_used && eff_s[iss_rs1]) ||
                       (iss_rs2_used && eff_s[iss_rs2]) ||
                       (iss_rd_used  && eff_s[iss_rd]);
        iss_ready    = (state_q == RUN) && !hazard_s;
        issue_fire_s = iss_valid && iss_ready;
        set_en_s     = issue_fire_s && iss_long && iss_rd_used && (iss_rd != CNT_ZERO);
        // Only a real pending bit retires an op, so a stray writeback never underflows.
        dec_s        = rf_we_q && pending_s[rf_waddr_q] && (cnt_q != CNT_ZERO);
        case ({set_en_s, dec_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Round-robin writeback arbiter and next RF write port contents.
    always_comb begin
        ld_gnt_s   = ld_wb_valid && (!md_wb_valid || (rr_last_q == WB_MD));
        md_gnt_s   = md_wb_valid && (!ld_wb_valid || (rr_last_q == WB_LD));
        rr_last_d  = rr_last_q;
        rf_we_d    = ld_gnt_s || md_gnt_s;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (ld_wb_valid && md_wb_valid) begin
            rr_last_d = ld_gnt_s ? WB_LD : WB_MD;
        end else begin
            rr_last_d = rr_last_q;
        end
        if (ld_gnt_s) begin
            rf_waddr_d = ld_wb_rd;
            rf_wdata_d = ld_wb_data;
        end else if (md_gnt_s) begin
            rf_waddr_d = md_wb_rd;
            rf_wdata_d = md_wb_data;
        end else begin
            rf_waddr_d = rf_waddr_q;
            rf_wdata_d = rf_wdata_q;
        end
    end

    // Fence sequencing; a request held high through its own ack is not re-acknowledged,
    // and DRAIN exits on the cycle the last clear lands so the ack coincides with idle.
    always_comb begin
        state_d     = state_q;
        fence_ack_d = 1'b0;
        case (state_q)
            RUN: begin
                if (fence_req && !fence_ack_q) begin
                    if (cnt_d != CNT_ZERO) begin
                        state_d = DRAIN;
                    end else begin
                        fence_ack_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (cnt_d == CNT_ZERO) begin
                    state_d     = RUN;
                    fence_ack_d = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Control and writeback port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= CNT_ZERO;
            rr_last_q   <= WB_MD;
            state_q     <= RUN;
            fence_ack_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= CNT_ZERO;
            rf_wdata_q  <= {XLEN{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            state_q     <= state_d;
            fence_ack_q <= fence_ack_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign ld_wb_ready = ld_gnt_s;
    assign md_wb_ready = md_gnt_s;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign fence_ack   = fence_ack_q;
    assign idle        = (cnt_q == CNT_ZERO);

endmodule
